// File: rtl/config_routing_mux.sv
// Scan-configured N:1 routing mux: a serial shadow selector, a commit-loaded active selector,
// and a binary select tree that is either combinational or registered after every level.
module config_routing_mux #(
  parameter int INPUTS    = 26,
  parameter int SEL_WIDTH = $clog2(INPUTS),
  parameter bit PIPELINED = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              config_enable,
  input  logic              config_in,
  output logic              config_out,
  input  logic              config_commit,
  input  logic [INPUTS-1:0] data_in,
  output logic              data_out
);

  localparam int EXT = 1 << SEL_WIDTH;

  logic [SEL_WIDTH-1:0] r_shadow;
  logic [SEL_WIDTH-1:0] r_active;
  logic [SEL_WIDTH-1:0] w_shadowNext;

  assign w_shadowNext = SEL_WIDTH'({config_in, r_shadow} >> 1);

  // Commit copies the pre-edge shadow, so a shift in the same cycle does not leak into active.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (config_enable) r_shadow <= w_shadowNext;
      if (config_commit) r_active <= r_shadow;
    end
  end

  assign config_out = r_shadow[0];

  for (genvar k = SEL_WIDTH; k >= 1; k--) begin : g_level
    logic [(1<<k)-1:0]     w_in;
    logic [k-1:0]          w_sin;
    logic [(1<<(k-1))-1:0] w_half;
    logic [(1<<(k-1))-1:0] w_out;

    // Zero-extension makes out-of-range selectors route constant 0.
    if (k == SEL_WIDTH) begin : g_top
      assign w_in  = EXT'(data_in);
      assign w_sin = r_active;
    end else begin : g_inner
      assign w_in  = g_level[k+1].w_out;
      assign w_sin = g_level[k+1].g_sel.w_sout;
    end

    assign w_half = w_sin[k-1] ? w_in[(1<<k)-1 -: (1<<(k-1))] : w_in[(1<<(k-1))-1:0];

    if (PIPELINED) begin : g_pipe
      logic [(1<<(k-1))-1:0] r_half;
      always_ff @(posedge clock) begin
        if (reset) r_half <= '0;
        else       r_half <= w_half;
      end
      assign w_out = r_half;
    end else begin : g_comb
      assign w_out = w_half;
    end

    // Remaining selector bits travel with their data so each output uses one consistent selector.
    if (k > 1) begin : g_sel
      logic [k-2:0] w_sout;
      if (PIPELINED) begin : g_pipe
        logic [k-2:0] r_sel;
        always_ff @(posedge clock) begin
          if (reset) r_sel <= '0;
          else       r_sel <= w_sin[k-2:0];
        end
        assign w_sout = r_sel;
      end else begin : g_comb
        assign w_sout = w_sin[k-2:0];
      end
    end
  end

  assign data_out = g_level[1].w_out[0];

endmodule

// File: tb/tb_config_routing_mux.sv
// Self-checking bench: combinational and pipelined instances share stimulus and are compared
// every cycle against a queue-based behavioural model, plus hand-computed directed checks.
module tb_config_routing_mux;

  localparam int INPUTS = 26;
  localparam int S      = 5;

  logic              clock;
  logic              reset;
  logic              configEnable;
  logic              configIn;
  logic              configCommit;
  logic [INPUTS-1:0] dataIn;
  logic              dataOutComb;
  logic              dataOutPipe;
  logic              cfgOutComb;
  logic              cfgOutPipe;

  int nCompared   = 0;
  int nMismatched = 0;

  config_routing_mux #(.INPUTS(INPUTS), .PIPELINED(1'b0)) dutComb (
    .clock(clock), .reset(reset), .config_enable(configEnable), .config_in(configIn),
    .config_out(cfgOutComb), .config_commit(configCommit), .data_in(dataIn), .data_out(dataOutComb)
  );

  config_routing_mux #(.INPUTS(INPUTS), .PIPELINED(1'b1)) dutPipe (
    .clock(clock), .reset(reset), .config_enable(configEnable), .config_in(configIn),
    .config_out(cfgOutPipe), .config_commit(configCommit), .data_in(dataIn), .data_out(dataOutPipe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state: config bits shifted since reset (newest at back), active selector,
  // and expected pipelined outputs (newest at front).
  int   mHist[$];
  int   mActive;
  logic mPipe[$];
  bit   modelReady = 1'b0;

  function automatic int shadowValue();
    int v = 0;
    for (int j = 0; j < S; j++)
      if (j < mHist.size()) v |= mHist[mHist.size()-1-j] << (S-1-j);
    return v;
  endfunction

  function automatic logic routed(input int sel, input logic [INPUTS-1:0] d);
    if (sel < INPUTS) return d[sel];
    return 1'b0;
  endfunction

  function automatic logic expCfgOut();
    if (mHist.size() == S) return mHist[0][0];
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cin, input logic commit,
                               input logic rst, input logic [INPUTS-1:0] d);
    @(posedge clock);
    #1;
    configEnable = en;
    configIn     = cin;
    configCommit = commit;
    reset        = rst;
    dataIn       = d;
  endtask

  task automatic shiftValue(input int value, input logic [INPUTS-1:0] d);
    for (int j = 0; j < S; j++) applyStimulus(1'b1, value[j], 1'b0, 1'b0, d);
  endtask

  always @(posedge clock) begin
    logic v;
    int   oldShadow;
    v = routed(mActive, dataIn);
    if (reset) begin
      mHist.delete();
      mActive = 0;
      mPipe.delete();
      for (int j = 0; j < S; j++) mPipe.push_back(1'b0);
    end else begin
      oldShadow = shadowValue();
      if (configEnable) begin
        mHist.push_back(int'(configIn));
        if (mHist.size() > S) void'(mHist.pop_front());
      end
      if (configCommit) mActive = oldShadow;
      mPipe.push_front(v);
      void'(mPipe.pop_back());
    end
    modelReady = 1'b1;
  end

  always @(negedge clock) begin
    if (modelReady) begin
      checkOutput("modelCombOut", dataOutComb, routed(mActive, dataIn));
      checkOutput("modelPipeOut", dataOutPipe, mPipe[S-1]);
      checkOutput("modelCfgOutComb", cfgOutComb, expCfgOut());
      checkOutput("modelCfgOutPipe", cfgOutPipe, expCfgOut());
    end
  end

  initial begin
    logic [0:9] seq;
    logic [0:7] pat;
    logic [INPUTS-1:0] d;
    seq = 10'b1101001110;
    pat = 8'b10110010;

    reset = 1'b1; configEnable = 1'b0; configIn = 1'b0; configCommit = 1'b0;
    dataIn = 26'h1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 26'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 26'h1);
    @(negedge clock);
    checkOutput("resetCombOut", dataOutComb, 1'b1);
    checkOutput("resetPipeOut", dataOutPipe, 1'b0);
    checkOutput("resetCfgOut", cfgOutComb, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    checkOutput("releaseCombOut", dataOutComb, 1'b0);

    // Load 17 LSB-first; input 0 still routed until commit.
    shiftValue(17, 26'h1);
    @(negedge clock);
    checkOutput("preCommitCombOut", dataOutComb, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 26'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'(1 << 17));
    @(negedge clock);
    checkOutput("sel17One", dataOutComb, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, ~26'(1 << 17));
    @(negedge clock);
    checkOutput("sel17Zero", dataOutComb, 1'b0);

    // Chain pass-through: config_out replays the sequence five cycles later.
    for (int j = 0; j < 12; j++) begin
      applyStimulus(j < 10, (j < 10) ? seq[j] : 1'b0, 1'b0, 1'b0, 26'(1 << 17));
      @(negedge clock);
      if (j >= 5 && j <= 10) checkOutput("chainCfgOut", cfgOutComb, seq[j-5]);
    end
    checkOutput("chainActiveKept", dataOutComb, 1'b1);

    // Out-of-range selector routes constant 0.
    shiftValue(29, '1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '1);
    @(negedge clock);
    checkOutput("outOfRange", dataOutComb, 1'b0);

    // Commit and shift together: active gets 9, shadow becomes 20.
    shiftValue(9, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'(1 << 9));
    @(negedge clock);
    checkOutput("commitShiftOld", dataOutComb, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 26'(1 << 9));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'(1 << 20));
    @(negedge clock);
    checkOutput("commitShiftNew", dataOutComb, 1'b1);

    // Reset alongside commit leaves active at 0.
    shiftValue(12, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'(1 << 12));
    @(negedge clock);
    checkOutput("resetCommitSel12", dataOutComb, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'h1);
    @(negedge clock);
    checkOutput("resetCommitSel0", dataOutComb, 1'b1);

    // Pipelined walk on input 3 with five-cycle latency.
    shiftValue(3, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int j = 0; j < 14; j++) begin
      d = 26'($urandom);
      d[3] = (j < 8) ? pat[j] : 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, d);
      @(negedge clock);
      if (j >= 5 && j <= 12) checkOutput("pipeWalk", dataOutPipe, pat[j-5]);
    end

    // Mid-stream commit to 7: in-flight data keeps selector 3.
    shiftValue(7, 26'(1 << 3));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 26'(1 << 3));
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 26'(1 << 3));
      @(negedge clock);
      if (j == 5) checkOutput("pipeOldSel", dataOutPipe, 1'b1);
      if (j == 6) checkOutput("pipeNewSel", dataOutPipe, 1'b0);
    end

    for (int j = 0; j < 3000; j++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
                    26'($urandom));
    end
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/config_routing_mux.md
# config_routing_mux

Parametrised, bitstream-configured N:1 routing multiplexer for the fabric's switch and connection boxes. The selector is loaded serially through the configuration scan chain into a shadow register. A commit pulse transfers it into an active register, so reconfiguration never glitches the routed signal. The binary select tree is optionally pipelined, with a registered stage after every halving level, for high-fanin routing at fabric clock rates.

## Interface
- INPUTS, 26: number of data inputs; legal range 2..256.
- SEL_WIDTH, $clog2(INPUTS): selector width; derived, never overridden.
- PIPELINED, 0: 0 = combinational tree; 1 = register after every tree level.
- clock  input  1  fabric/config clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- config_enable  input  1  shift one config bit per cycle while high.
- config_in  input  1  serial config bit in, from the previous chain element.
- config_out  output  1  serial config bit out, to the next chain element.
- config_commit  input  1  one-cycle pulse: shadow → active selector.
- data_in  input  INPUTS  routed candidates.
- data_out  output  1  selected signal.

## Operation
- Shadow register `shadow[SEL_WIDTH-1:0]`:
  - When config_enable is high, `shadow <= {config_in, shadow[SEL_WIDTH-1:1]}`.
  - When config_enable is low, shadow holds.
  - config_out = shadow[0] (registered); chain delay is exactly SEL_WIDTH cycles.
  - The bitstream is therefore loaded LSB-first.
- Active register `active[SEL_WIDTH-1:0]`:
  - On config_commit, `active <= shadow`, using the pre-edge value of shadow.
  - Otherwise active holds.
- Commit and shift in the same cycle: active takes the old shadow and shadow shifts. Both happen; there is no priority between them.
- Tree:
  - data_in is zero-extended to 2^SEL_WIDTH.
  - Level k (SEL_WIDTH..1) halves the vector using bit active[k-1]; MSB is used first.
  - Out-of-range selector (≥ INPUTS) routes constant 0.
- PIPELINED=1:
  - Each level's output is registered.
  - The remaining selector bits are registered alongside the data, so every output corresponds to one consistent (data_in, active) sample taken at the same edge.
  - There are no mixed-selector outputs across a commit.
- Reset, which dominates every other input:
  - shadow=0, active=0, config_out=0.
  - All pipeline data and selector registers = 0.
  - data_out=0 (PIPELINED=1); in the combinational case data_out = data_in[0].
- Reset asserted mid-load discards partial shadow contents. Reset in the same cycle as config_commit leaves active=0.

## Timing
- PIPELINED=0: data_out is combinational from data_in and active. A new selector is visible in the cycle after the commit edge.
- PIPELINED=1: latency is SEL_WIDTH cycles from data_in sample to data_out, with throughput 1/cycle. The first output after reset is valid SEL_WIDTH cycles after reset deasserts; before that data_out=0.
- Commit with PIPELINED=1: outputs switch selector exactly SEL_WIDTH cycles after the commit edge +1. Outputs in flight keep the old selector.
- config_out changes only on clock edges where config_enable=1 or reset=1.
- Full load: SEL_WIDTH cycles of config_enable, then 1 cycle of config_commit (this may overlap the last shift only if the old value is intended).

## Test plan
- Reset, INPUTS=26, PIPELINED=0: hold reset 2 cycles with data_in=26'h1 → data_out=1; config_out=0; after release data_in=0 → data_out=0.
- Load selector 5'd17:
  - Stimulus: shift bits 1,0,0,0,1 (LSB-first) over 5 cycles, then commit.
  - Before commit: data_out still follows input 0.
  - After commit, data_in=1<<17 → data_out=1; data_in=~(1<<17) → data_out=0.
- Out of range: load and commit 5'd29, data_in=all ones → data_out=0.
- Chain pass-through: shift 10 bits 1101001110 with no commit → config_out reproduces the sequence delayed by 5 cycles; active unchanged.
- PIPELINED=1, selector 3:
  - Drive a walking pattern on data_in[3] → data_out follows with exactly 5-cycle latency.
  - Commit selector 7 mid-stream → the switch occurs with no output taken from a mixed selector.
- Simultaneous events:
  - Commit and shift in the same cycle: active = pre-shift shadow.
  - Reset in the same cycle as commit: active=0, data_out tracks data_in[0].
